voxel_mem_arbiter: RTL and testbench
====================================

# voxel_mem_arbiter

Shares the single-read/single-write voxel occupancy RAM (32K x 1) between `NUM_REQ` ray-traversal read requesters and one scene loader. Reads are granted round-robin with valid/ready handshakes; responses are returned one-hot-tagged after the RAM read latency. A three-state mode FSM gives the loader exclusive write access, draining in-flight reads before granting. Sits between the traversal units and `voxel_ram`.

## Interface
- `NUM_REQ`, 4: number of read requesters, 2..8
- `ADDR_W`, 15: voxel address width
- `SYNC_READ`, 1: must match the RAM setting; 1 = one-cycle read latency, 0 = combinational read
- `clock` in 1: sole clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `rd_req_valid` in NUM_REQ: per-requester read request
- `rd_req_addr` in NUM_REQ*ADDR_W: packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- `rd_req_ready` out NUM_REQ: one-hot accept, combinational
- `rd_rsp_valid` out NUM_REQ: one-hot response strobe
- `rd_rsp_data` out 1: occupancy bit for the strobed requester
- `ld_req` in 1: loader requests write mode, level
- `ld_grant` out 1: write mode active
- `ld_wr_en`, `ld_wr_addr`, `ld_wr_data` in 1/ADDR_W/1: loader write
- `ld_done` in 1: single-cycle pulse ending write mode
- `ld_err` out 1: sticky; loader write attempted without grant
- `ram_wr_en`, `ram_wr_addr`, `ram_wr_data` out 1/ADDR_W/1: to RAM write port
- `ram_rd_addr` out ADDR_W: to RAM read port
- `ram_rd_data` in 1: from RAM

## Operation
- FSM states: TRACE, DRAIN, LOAD. Reset state is TRACE.
- TRACE:
  - Winner = first i with `rd_req_valid[i]`, searching from `ptr` upward with wrap.
  - `rd_req_ready[winner]`=1 and `ram_rd_addr`=winner's address. With no winner, `ram_rd_addr`=0.
  - On accept, `ptr` becomes winner+1, wrapping from NUM_REQ-1 to 0. Otherwise `ptr` holds.
  - `ld_req`=1 moves the FSM to DRAIN. A read accepted in that same cycle still completes.
- DRAIN:
  - No reads are accepted.
  - The FSM moves to LOAD once no read is pending and `ld_req`=1.
  - If `ld_req` drops, the FSM returns to TRACE.
  - DRAIN always lasts at least one cycle.
- LOAD:
  - `ld_grant`=1.
  - `ram_wr_*` follow `ld_wr_*` combinationally.
  - `ld_done`=1 returns the FSM to TRACE; a write in that same cycle is still performed.
- Outside LOAD:
  - `ram_wr_en`=0.
  - `ld_wr_en`=1 sets `ld_err`; only reset clears it.
  - `ld_done` is ignored.
- Reset values: `rd_rsp_valid`=0, `rd_rsp_data`=0, `ld_grant`=0, `ld_err`=0, `ptr`=0, no read pending. Reset may be asserted mid-read or mid-load; a pending response is discarded.

## Timing
- SYNC_READ=1:
  - Accept in cycle N gives `rd_rsp_valid[winner]`=1 in N+1, with `rd_rsp_data`=`ram_rd_data`.
  - Pending flag is set N->N+1.
- SYNC_READ=0: response is combinational in cycle N, and there is never a pending read.
- Throughput: one read per cycle in TRACE.
- `ld_grant` is registered. It rises in the first cycle of LOAD, at the earliest 2 cycles after `ld_req` rises, and falls the cycle after `ld_done`.
- No requester starves: a valid requester is served within NUM_REQ accepts.

## Configuration
- `VOXEL_ARB_STATS_EN` defined adds these outputs, both cleared by reset:
  - `stat_grants` (32 bit, wraps): read accepts.
  - `stat_stall_cycles` (32 bit, wraps): cycles with any `rd_req_valid` and no accept.
- `VOXEL_ARB_STATS_EN` undefined: these ports and counters do not exist.

## Structure
- Package `voxel_pkg`:
  - `VOXEL_ADDR_W`=15.
  - `voxel_arb_state_t` enum {TRACE, DRAIN, LOAD}.
- Sub-module `rr_arbiter`: takes the request vector and `ptr`, and produces the one-hot grant and the next `ptr`.

## Test plan
- Requesters 0..3 valid continuously, SYNC_READ=1 -> accepts in order 0,1,2,3,0; each `rd_rsp_valid` follows one cycle after its accept with the correct preloaded bits.
- Only requester 2 valid, addr 0x1234 holding 1 -> ready[2] every cycle; `rd_rsp_data`=1 each following cycle.
- `ld_req` raised in the same cycle req 1 is accepted -> response still delivered; `ld_grant` rises 2 cycles later; no reads accepted in DRAIN or LOAD.
- LOAD: write 1 to 0x7FFF, then `ld_done` -> back to TRACE; a read of 0x7FFF returns 1.
- `ld_wr_en` pulsed in TRACE -> `ram_wr_en` stays 0, `ld_err`=1 until `reset_n` is asserted.
- `reset_n` asserted mid-LOAD -> `ld_grant`=0 and `rd_rsp_valid`=0 immediately; FSM in TRACE after release.

Source files
------------

// File: rtl/voxel_pkg.sv
// Shared constants and state type for the voxel occupancy RAM arbiter.
package voxel_pkg;

  localparam int unsigned VOXEL_ADDR_W = 15;

  typedef enum logic [1:0] {
    TRACE,
    DRAIN,
    LOAD
  } voxel_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr_i (with wrap),
// plus the pointer value that follows the winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o,
  output logic [$clog2(NUM_REQ)-1:0] ptr_nxt_o
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        idx_o          = cand;
        grant_o[cand]  = 1'b1;
      end
    end
    ptr_nxt_o = (32'(idx_o) == NUM_REQ - 1) ? '0 : idx_o + 1'b1;
  end

endmodule

// File: rtl/voxel_mem_arbiter.sv
// Shares the 32K x 1 voxel RAM between NUM_REQ round-robin readers and a scene loader.
// Define VOXEL_ARB_STATS_EN to add the stat_grants / stat_stall_cycles counters.
module voxel_mem_arbiter
  import voxel_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = VOXEL_ADDR_W,
  parameter bit          SYNC_READ = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        rd_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_req_addr,
  output logic [NUM_REQ-1:0]        rd_req_ready,
  output logic [NUM_REQ-1:0]        rd_rsp_valid,
  output logic                      rd_rsp_data,
  input  logic                      ld_req,
  output logic                      ld_grant,
  input  logic                      ld_wr_en,
  input  logic [ADDR_W-1:0]         ld_wr_addr,
  input  logic                      ld_wr_data,
  input  logic                      ld_done,
  output logic                      ld_err,
  output logic                      ram_wr_en,
  output logic [ADDR_W-1:0]         ram_wr_addr,
  output logic                      ram_wr_data,
  output logic [ADDR_W-1:0]         ram_rd_addr,
  input  logic                      ram_rd_data
`ifdef VOXEL_ARB_STATS_EN
  ,
  output logic [31:0]               stat_grants,
  output logic [31:0]               stat_stall_cycles
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  voxel_arb_state_t   state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] tag_q;
  logic               arb_any;
  logic               accept;
  logic               pend_q;
  logic               grant_q;
  logic               err_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i     (rd_req_valid),
    .ptr_i     (ptr_q),
    .grant_o   (arb_grant),
    .idx_o     (win_idx),
    .any_o     (arb_any),
    .ptr_nxt_o (ptr_nxt)
  );

  always_comb begin
    rd_req_ready = '0;
    ram_rd_addr  = '0;
    accept       = 1'b0;
    if (state_q == TRACE && arb_any) begin
      rd_req_ready = arb_grant;
      accept       = 1'b1;
      ram_rd_addr  = rd_req_addr[32'(win_idx)*ADDR_W +: ADDR_W];
    end
  end

  assign ram_wr_en   = grant_q & ld_wr_en;
  assign ram_wr_addr = ld_wr_addr;
  assign ram_wr_data = ld_wr_data;
  assign ld_grant    = grant_q;
  assign ld_err      = err_q;

  generate
    if (SYNC_READ) begin : g_sync_rsp
      assign rd_rsp_valid = tag_q;
      assign rd_rsp_data  = pend_q & ram_rd_data;
    end else begin : g_comb_rsp
      assign rd_rsp_valid = rd_req_ready;
      assign rd_rsp_data  = accept & ram_rd_data;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TRACE;
      grant_q <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      pend_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      if (accept) ptr_q <= ptr_nxt;
      pend_q <= SYNC_READ & accept;
      tag_q  <= SYNC_READ ? rd_req_ready : '0;
      if (ld_wr_en && state_q != LOAD) err_q <= 1'b1;
      unique case (state_q)
        TRACE: if (ld_req) state_q <= DRAIN;
        // Accepts stop on entering DRAIN, so the last in-flight read returns
        // during this cycle and nothing is pending at its end.
        DRAIN: begin
          if (ld_req) begin
            state_q <= LOAD;
            grant_q <= 1'b1;
          end else begin
            state_q <= TRACE;
          end
        end
        LOAD: begin
          if (ld_done) begin
            state_q <= TRACE;
            grant_q <= 1'b0;
          end
        end
        default: begin
          state_q <= TRACE;
          grant_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VOXEL_ARB_STATS_EN
  logic [31:0] grants_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      if (accept) grants_q <= grants_q + 32'd1;
      if (|rd_req_valid && !accept) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_grants       = grants_q;
  assign stat_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_voxel_mem_arbiter.sv
// Randomized scoreboard bench for voxel_mem_arbiter with a behavioural RAM and reference model.
`timescale 1ns/1ps
module tb_voxel_mem_arbiter;
  import voxel_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = VOXEL_ADDR_W;
  typedef logic [AW-1:0] addr_t;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    rd_req_valid = '0;
  logic [N*AW-1:0] rd_req_addr = '0;
  logic [N-1:0]    rd_req_ready, rd_rsp_valid;
  logic            rd_rsp_data;
  logic            ld_req = 1'b0, ld_grant, ld_wr_en = 1'b0, ld_wr_data = 1'b0, ld_done = 1'b0, ld_err;
  addr_t           ld_wr_addr = '0;
  logic            ram_wr_en, ram_wr_data, ram_rd_data;
  addr_t           ram_wr_addr, ram_rd_addr;
`ifdef VOXEL_ARB_STATS_EN
  logic [31:0]     stat_grants, stat_stall_cycles;
`endif

  always #5 clock = ~clock;

  voxel_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .SYNC_READ(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .ld_req(ld_req), .ld_grant(ld_grant), .ld_wr_en(ld_wr_en), .ld_wr_addr(ld_wr_addr),
    .ld_wr_data(ld_wr_data), .ld_done(ld_done), .ld_err(ld_err),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
`ifdef VOXEL_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  // Voxel RAM: unwritten cells hold a pseudo-random preload pattern.
  int unsigned salt;
  bit ram_mem [addr_t];
  bit ref_mem [addr_t];
  logic ram_q = 1'b0;
  assign ram_rd_data = ram_q;

  function automatic logic init_bit(input addr_t a);
    logic [31:0] h;
    h = (32'(a) * 32'h9E3779B1) ^ salt;
    return h[31] ^ h[13];
  endfunction

  function automatic logic ref_rd(input addr_t a);
    return ref_mem.exists(a) ? ref_mem[a] : init_bit(a);
  endfunction

  always @(posedge clock) begin
    ram_q <= ram_mem.exists(ram_rd_addr) ? ram_mem[ram_rd_addr] : init_bit(ram_rd_addr);
    if (ram_wr_en) ram_mem[ram_wr_addr] = ram_wr_data;
  end

  // Scoreboard
  typedef struct { int idx; logic [N-1:0] ready; addr_t raddr; logic wr_en; addr_t waddr;
                   logic wdata; logic grant; logic err; } cyc_exp_t;
  typedef struct { int due; logic [N-1:0] tag; logic data; } rsp_exp_t;
  cyc_exp_t exp_q[$];
  rsp_exp_t rsp_q[$];
  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: the mode is tracked as plain flags following the loader rules.
  int m_ptr = 0, cyc = 0, n_acc = 0, n_stall = 0;
  bit m_drain = 0, m_load = 0, m_err = 0;
  logic [N-1:0] s_valid = '0;
  addr_t s_addr [N];
  bit s_ldreq = 0, s_wen = 0, s_wdata = 0, s_done = 0;
  addr_t s_waddr = '0;

  task automatic model_reset();
    m_ptr = 0; m_drain = 0; m_load = 0; m_err = 0;
    exp_q.delete(); rsp_q.delete();
  endtask

  task automatic tick();
    cyc_exp_t e;
    rsp_exp_t r;
    int win, j;
    @(negedge clock);
    rd_req_valid = s_valid;
    for (int i = 0; i < N; i++) rd_req_addr[i*AW +: AW] = s_addr[i];
    ld_req = s_ldreq; ld_wr_en = s_wen; ld_wr_addr = s_waddr; ld_wr_data = s_wdata; ld_done = s_done;
    win = -1;
    if (!m_drain && !m_load)
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (win < 0 && s_valid[j]) win = j;
      end
    e.idx = cyc; e.ready = '0; e.raddr = '0;
    e.wr_en = m_load && s_wen; e.waddr = s_waddr; e.wdata = s_wdata;
    e.grant = m_load; e.err = m_err;
    if (win >= 0) begin
      e.ready[win] = 1'b1;
      e.raddr = s_addr[win];
      r.due = cyc + 1; r.tag = '0; r.tag[win] = 1'b1; r.data = ref_rd(s_addr[win]);
      rsp_q.push_back(r);
      m_ptr = (win + 1) % N;
      n_acc++;
    end else if (|s_valid) n_stall++;
    exp_q.push_back(e);
    if (m_load && s_wen) ref_mem[s_waddr] = s_wdata;
    if (s_wen && !m_load) m_err = 1;
    if (m_load) begin
      if (s_done) m_load = 0;
    end else if (m_drain) begin
      m_drain = 0;
      m_load = s_ldreq;
    end else if (s_ldreq) m_drain = 1;
    cyc++;
  endtask

  // Monitor
  initial begin
    cyc_exp_t e;
    rsp_exp_t r;
    forever begin
      @(negedge clock); #4;
      if (chk_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_req_ready", 32'(rd_req_ready), 32'(e.ready));
        chk("ram_rd_addr", 32'(ram_rd_addr), 32'(e.raddr));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(e.wr_en));
        chk("ld_grant", 32'(ld_grant), 32'(e.grant));
        chk("ld_err", 32'(ld_err), 32'(e.err));
        if (e.wr_en) begin
          chk("ram_wr_addr", 32'(ram_wr_addr), 32'(e.waddr));
          chk("ram_wr_data", 32'(ram_wr_data), 32'(e.wdata));
        end
        if (rd_rsp_valid != '0) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rd_rsp_valid), 32'd0);
          else begin
            r = rsp_q.pop_front();
            chk("rsp_tag", 32'(rd_rsp_valid), 32'(r.tag));
            chk("rsp_cycle", 32'(e.idx), 32'(r.due));
            chk("rsp_data", 32'(rd_rsp_data), 32'(r.data));
          end
        end else if (rsp_q.size() > 0 && rsp_q[0].due <= e.idx) begin
          r = rsp_q.pop_front();
          chk("rsp_missing", 32'(rd_rsp_valid), 32'(r.tag));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic addr_t pick();
    case ($urandom_range(0, 4))
      0: return 15'h7FFF;
      1: return 15'h1234;
      2: return 15'h0042;
      3: return 15'h0100;
      default: return addr_t'($urandom);
    endcase
  endfunction

  task automatic drive_idle();
    rd_req_valid = '0; ld_req = 0; ld_wr_en = 0; ld_done = 0;
    s_valid = '0; s_ldreq = 0; s_wen = 0; s_done = 0;
  endtask

  initial begin
    salt = $urandom;
    for (int i = 0; i < N; i++) s_addr[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rd_rsp_data), 32'd0);
    chk("reset_ld_grant", 32'(ld_grant), 32'd0);
    chk("reset_ld_err", 32'(ld_err), 32'd0);
    @(negedge clock); reset_n = 1'b1; chk_en = 1'b1;

    // All four requesters continuously valid: order 0,1,2,3,0,1
    s_valid = 4'hF;
    for (int i = 0; i < N; i++) s_addr[i] = pick();
    repeat (6) tick();

    // ld_req in the same cycle requester 1 is accepted, then load writes
    s_valid = 4'b0010; s_addr[1] = 15'h0100; s_ldreq = 1;
    tick();
    s_valid = 4'hF;
    tick();
    s_wen = 1; s_waddr = 15'h7FFF; s_wdata = 1; tick();
    s_waddr = 15'h1234; s_wdata = 1; tick();
    s_waddr = 15'h0042; s_wdata = ~init_bit(15'h0042); tick();
    s_waddr = 15'h0100; s_wdata = ~ref_rd(15'h0100); s_done = 1; tick();
    s_wen = 0; s_done = 0; s_ldreq = 0;

    // Read back 0x7FFF, then requester 2 alone on 0x1234
    s_valid = 4'b0001; s_addr[0] = 15'h7FFF; repeat (2) tick();
    s_valid = 4'b0100; s_addr[2] = 15'h1234; repeat (4) tick();

    // ld_req dropped during DRAIN aborts back to TRACE
    s_valid = 4'hF; s_ldreq = 1; tick();
    s_ldreq = 0; repeat (3) tick();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      s_valid = N'($urandom);
      for (int i = 0; i < N; i++) s_addr[i] = pick();
      if ($urandom_range(0, 9) == 0) s_ldreq = !s_ldreq;
      s_done = ($urandom_range(0, 5) == 0);
      s_wen = m_load && ($urandom_range(0, 2) == 0);
      s_waddr = pick(); s_wdata = 1'($urandom);
      tick();
    end
    s_ldreq = 0; s_wen = 0; s_done = 1; s_valid = '0;
    repeat (3) tick();
    s_done = 0;
    repeat (2) tick();
`ifdef VOXEL_ARB_STATS_EN
    #5;
    chk("stat_grants", stat_grants, 32'(n_acc));
    chk("stat_stall_cycles", stat_stall_cycles, 32'(n_stall));
`endif

    // Loader write outside LOAD: suppressed, sets sticky error
    s_wen = 1; s_waddr = 15'h0042; s_wdata = ~ref_rd(15'h0042); tick();
    s_wen = 0; repeat (3) tick();
    s_valid = 4'b0001; s_addr[0] = 15'h0042; tick();
    s_valid = '0; repeat (2) tick();

    // Reset while a read response is pending
    s_valid = 4'b0100; s_addr[2] = 15'h1234; tick();
    @(posedge clock); #1;
    chk_en = 0;
    chk("pending_rsp_before_rst", 32'(rd_rsp_valid), 32'b0100);
    reset_n = 1'b0; #1;
    chk("rst_mid_read_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    chk("rst_mid_read_rsp_data", 32'(rd_rsp_data), 32'd0);
    chk("rst_clears_ld_err", 32'(ld_err), 32'd0);
    model_reset();
    @(negedge clock); drive_idle(); reset_n = 1'b1; chk_en = 1;

    // Reset in the middle of LOAD
    s_valid = 4'hF; s_ldreq = 1; repeat (2) tick();
    s_wen = 1; s_waddr = 15'h0100; s_wdata = 1; tick();
    @(posedge clock); #1;
    chk_en = 0;
    chk("grant_before_rst", 32'(ld_grant), 32'(m_load));
    reset_n = 1'b0; #1;
    chk("rst_mid_load_grant", 32'(ld_grant), 32'd0);
    chk("rst_mid_load_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    chk("rst_mid_load_wr_en", 32'(ram_wr_en), 32'd0);
    model_reset();
    @(negedge clock); drive_idle(); reset_n = 1'b1; chk_en = 1;

    // Back in TRACE: round robin restarts from requester 0
    s_valid = 4'hF;
    for (int i = 0; i < N; i++) s_addr[i] = pick();
    repeat (5) tick();
    s_valid = '0; repeat (2) tick();
    #5;
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
